// File: rtl/ucie_sb_msg_link.sv
// ucie_sb_msg_link: serial sideband message link with REQ response timeout
module ucie_sb_msg_link #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_fsm_msg_out,
  output logic [3:0] o_fsm_msg_in,
  output logic       o_sb_tx,
  input  logic       i_sb_rx,
  output logic       o_tx_busy,
  output logic       o_rx_msg_valid,
  output logic       o_rx_err,
  output logic       o_rsp_timeout
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_st_t;
  tx_st_t r_tx_st, w_tx_nx;
  rx_st_t r_rx_st, w_rx_nx;
  logic [1:0] r_tx_idx, r_rx_idx;
  logic [3:0] r_tx_sh, r_last, r_rx_sh, r_exp, r_msg;
  logic r_rx_par, r_valid, r_err, r_armed, r_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic w_launch, w_rx_done, w_accept, w_req_stop, w_match;
  assign w_launch = (r_tx_st == TX_IDLE || r_tx_st == TX_STOP) && i_fsm_msg_out != 4'd0 &&
                    i_fsm_msg_out <= 4'd8 && i_fsm_msg_out != r_last;
  assign w_rx_done = r_rx_st == RX_STOP;
  assign w_accept = w_rx_done && !i_sb_rx && (^r_rx_sh == r_rx_par) && r_rx_sh != 4'd0 && r_rx_sh <= 4'd8;
  assign w_req_stop = r_tx_st == TX_STOP && r_tx_sh[0];
  assign w_match = r_armed && w_accept && r_rx_sh == r_exp;
  assign o_tx_busy = r_tx_st != TX_IDLE;
  assign o_fsm_msg_in = r_msg;
  assign o_rx_msg_valid = r_valid;
  assign o_rx_err = r_err;
  assign o_rsp_timeout = r_timeout;
  // TX next state and the bit currently on the lane
  always_comb begin
    w_tx_nx = r_tx_st;
    o_sb_tx = 1'b0;
    case (r_tx_st)
      TX_IDLE:  w_tx_nx = w_launch ? TX_START : TX_IDLE;
      TX_START: begin w_tx_nx = TX_DATA; o_sb_tx = 1'b1; end
      TX_DATA:  begin w_tx_nx = r_tx_idx == 2'd3 ? TX_PAR : TX_DATA; o_sb_tx = r_tx_sh[r_tx_idx]; end
      TX_PAR:   begin w_tx_nx = TX_STOP; o_sb_tx = ^r_tx_sh; end
      TX_STOP:  w_tx_nx = w_launch ? TX_START : TX_IDLE;
      default:  w_tx_nx = TX_IDLE;
    endcase
  end
  // TX state, bit index, frame code and last-sent code (IDLE input re-enables a repeat)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_st <= TX_IDLE;
      r_tx_idx <= 2'd0;
      r_tx_sh <= 4'd0;
      r_last <= 4'd0;
    end else begin
      r_tx_st <= w_tx_nx;
      r_tx_idx <= r_tx_st == TX_DATA ? r_tx_idx + 2'd1 : 2'd0;
      if (w_launch) begin
        r_tx_sh <= i_fsm_msg_out;
        r_last <= i_fsm_msg_out;
      end else if (i_fsm_msg_out == 4'd0) r_last <= 4'd0;
    end
  end
  // RX next state; a 1 on an idle line is a start bit
  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      RX_IDLE: w_rx_nx = i_sb_rx ? RX_DATA : RX_IDLE;
      RX_DATA: w_rx_nx = r_rx_idx == 2'd3 ? RX_PAR : RX_DATA;
      RX_PAR:  w_rx_nx = RX_STOP;
      default: w_rx_nx = RX_IDLE;
    endcase
  end
  // RX deserializer and accept/error pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_st <= RX_IDLE;
      r_rx_idx <= 2'd0;
      r_rx_sh <= 4'd0;
      r_rx_par <= 1'b0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
      r_msg <= 4'd0;
    end else begin
      r_rx_st <= w_rx_nx;
      r_rx_idx <= r_rx_st == RX_DATA ? r_rx_idx + 2'd1 : 2'd0;
      if (r_rx_st == RX_DATA) r_rx_sh[r_rx_idx] <= i_sb_rx;
      if (r_rx_st == RX_PAR) r_rx_par <= i_sb_rx;
      r_valid <= w_accept;
      r_err <= w_rx_done && !w_accept;
      if (w_accept) r_msg <= r_rx_sh;
    end
  end
  // response timer: armed by a REQ stop bit, disarmed by the matching RSP, which beats expiry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_armed <= 1'b0;
      r_exp <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_req_stop) begin
        r_cnt <= CNT_W'(TIMEOUT_CYC);
        r_armed <= 1'b1;
        r_exp <= r_tx_sh + 4'd1;
      end else if (r_armed) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_match) r_armed <= 1'b0;
        else if (r_cnt == CNT_W'(1)) begin
          r_armed <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
      if (w_launch && i_fsm_msg_out[0]) r_timeout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ucie_sb_msg_link.sv
// tb_ucie_sb_msg_link: scoreboard bench with a transaction-level reference model
module tb_ucie_sb_msg_link;
  localparam int TO = 16;
  logic clk = 0, rst = 1, loop = 1, rx_drv = 0;
  logic [3:0] msg_out = 0, msg_in;
  logic sb_tx, sb_rx, busy, rxv, rxe, tmo;
  always #5 clk = ~clk;
  assign sb_rx = loop ? sb_tx : rx_drv;

  ucie_sb_msg_link #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_fsm_msg_out(msg_out), .o_fsm_msg_in(msg_in),
    .o_sb_tx(sb_tx), .i_sb_rx(sb_rx), .o_tx_busy(busy), .o_rx_msg_valid(rxv),
    .o_rx_err(rxe), .o_rsp_timeout(tmo));

  typedef struct {int cyc; logic [3:0] code;} tx_e_t;
  typedef struct {int cyc; bit ok; logic [3:0] msg;} rx_e_t;
  typedef struct {int cyc; bit lvl;} to_e_t;
  tx_e_t tx_q[$];
  rx_e_t rx_q[$];
  to_e_t to_q[$];
  logic [3:0] acc[int];
  logic [3:0] req_stop[int];
  int cyc = 0, free_at = 0, deadline = 0, errors = 0, checks = 0, nframes = 0;
  logic [3:0] last = 0, expc = 0, mdl_msg = 0;
  bit armed = 0, sticky = 0, rst_q = 1;
  logic [6:0] last_frame = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [3:0] c);
    return c != 4'd0 && c <= 4'd8;
  endfunction

  function automatic logic [6:0] frame(input logic [3:0] c);
    return {1'b0, ^c, c, 1'b1};
  endfunction

  task automatic push_rx(input int c, input bit ok, input logic [3:0] code);
    if (ok) begin
      mdl_msg = code;
      acc[c] = code;
    end
    rx_q.push_back('{c, ok, mdl_msg});
  endtask

  // reference model: decides per clock edge what the link must do
  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
    if (rst) begin
      tx_q.delete(); rx_q.delete(); acc.delete(); req_stop.delete();
      last = 0; free_at = 0; armed = 0; mdl_msg = 0;
      if (sticky) begin to_q.push_back('{cyc, 1'b0}); sticky = 0; end
    end else begin
      if (req_stop.exists(cyc)) begin
        armed = 1; deadline = cyc + TO; expc = req_stop[cyc] + 4'd1;
      end else if (armed && acc.exists(cyc) && acc[cyc] == expc) armed = 0;
      else if (armed && cyc == deadline) begin
        armed = 0;
        if (!sticky) begin to_q.push_back('{cyc, 1'b1}); sticky = 1; end
      end
      if (cyc >= free_at && legal(msg_out) && msg_out != last) begin
        last = msg_out; free_at = cyc + 7;
        tx_q.push_back('{cyc, msg_out});
        if (loop) push_rx(cyc + 7, 1'b1, msg_out);
        if (msg_out[0]) begin
          req_stop[cyc + 7] = msg_out;
          if (sticky) begin
            if (to_q.size() > 0 && to_q[$].cyc == cyc && to_q[$].lvl) void'(to_q.pop_back());
            else to_q.push_back('{cyc, 1'b0});
            sticky = 0;
          end
        end
      end else if (msg_out == 4'd0) last = 0;
    end
  end

  // TX monitor: reassembles frames from the lane and scores them
  int nb = 0, st = 0;
  logic [6:0] bits;
  bit bz;
  always @(negedge clk) begin
    tx_e_t e;
    if (rst_q) nb = 0;
    else if (nb == 0) begin
      if (sb_tx) begin nb = 1; bits = 7'b1; st = cyc; bz = busy; end
    end else begin
      bits[nb] = sb_tx; bz &= busy; nb++;
      if (nb == 7) begin
        nb = 0; nframes++; last_frame = bits;
        if (tx_q.size() == 0) check("tx_unexpected_frame", int'(bits), -1);
        else begin
          e = tx_q.pop_front();
          check("tx_frame_bits", int'(bits), int'(frame(e.code)));
          check("tx_start_cycle", st, e.cyc);
          check("tx_busy_in_frame", int'(bz), 1);
        end
      end
    end
  end

  // RX monitor: scores every valid/err pulse
  always @(negedge clk) begin
    rx_e_t e;
    if (!rst_q && (rxv || rxe)) begin
      if (rx_q.size() == 0) check("rx_unexpected_event", cyc, -1);
      else begin
        e = rx_q.pop_front();
        check("rx_event_cycle", cyc, e.cyc);
        check("rx_valid", int'(rxv), int'(e.ok));
        check("rx_err", int'(rxe), int'(!e.ok));
        check("rx_msg_in", int'(msg_in), int'(e.msg));
      end
    end
  end

  // timeout monitor: scores every change of the sticky flag
  bit prev_t = 0;
  always @(negedge clk) begin
    to_e_t e;
    if (tmo !== prev_t) begin
      if (to_q.size() == 0) check("timeout_unexpected_change", int'(tmo), -1);
      else begin
        e = to_q.pop_front();
        check("timeout_cycle", cyc, e.cyc);
        check("timeout_level", int'(tmo), int'(e.lvl));
      end
      prev_t = tmo;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input logic [6:0] f);
    logic [3:0] c;
    c = f[4:1];
    push_rx(cyc + 7, (^c == f[5]) && !f[6] && legal(c), c);
    for (int i = 0; i < 7; i++) begin rx_drv = f[i]; tick(1); end
    rx_drv = 0;
  endtask

  int n0;
  initial begin
    tick(3);
    check("rst_sb_tx", int'(sb_tx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_msg_in", int'(msg_in), 0);
    check("rst_rx_valid", int'(rxv), 0);
    check("rst_rx_err", int'(rxe), 0);
    check("rst_timeout", int'(tmo), 0);
    rst = 0; tick(2);
    msg_out = 1; tick(9);
    check("act_req_wire", int'(last_frame), int'(7'b0100011));
    check("loopback_msg_in", int'(msg_in), 1);
    tick(30);
    msg_out = 3; tick(30);
    check("retrain_timeout_high", int'(tmo), 1);
    msg_out = 1; tick(2);
    check("act_req_clears_timeout", int'(tmo), 0);
    tick(30);
    loop = 0;
    msg_out = 5; tick(10);
    drive_rx(7'b0001101); tick(20);
    check("lnkerr_rsp_msg_in", int'(msg_in), 6);
    check("lnkerr_rsp_no_timeout", int'(tmo), 0);
    msg_out = 0; tick(1);
    msg_out = 5; tick(17);
    drive_rx(7'b0001101); tick(20);
    check("coincident_accept_no_timeout", int'(tmo), 0);
    drive_rx(7'b0000101); tick(2);
    drive_rx(7'b0011111); tick(2);
    drive_rx(7'b1000011); tick(3);
    check("errors_hold_msg_in", int'(msg_in), 6);
    n0 = nframes;
    msg_out = 2; tick(50);
    msg_out = 0; tick(1);
    msg_out = 2; tick(12);
    msg_out = 3; tick(2);
    msg_out = 7; tick(15);
    check("repeat_and_newest_frames", nframes - n0, 4);
    check("newest_frame_is_7", int'(last_frame), int'(frame(4'd7)));
    msg_out = 4; tick(4);
    rst = 1; tick(1);
    check("midrst_sb_tx", int'(sb_tx), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_msg_in", int'(msg_in), 0);
    check("midrst_timeout", int'(tmo), 0);
    rst = 0; tick(10);
    check("retransmit_after_rst", int'(last_frame), int'(7'b0101001));
    loop = 1;
    repeat (60) begin
      msg_out = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      tick($urandom_range(1, 12));
    end
    tick(40);
    loop = 0;
    repeat (40) begin
      drive_rx({$urandom_range(0, 3) == 0, 5'($urandom), 1'b1});
      tick($urandom_range(1, 4));
    end
    tick(30);
    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
    check("timeout_queue_drained", to_q.size(), 0);
    check("tx_no_partial_frame", nb, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
